// File: rtl/spram_arbiter_pkg.sv
// Shared types for the SPRAM arbiter slice.
// Power states, SPRAM geometry and the request bundle.
package spram_arb_pkg;

  localparam int SPRAM_AW = 17;
  localparam int SPRAM_DW = 8;

  typedef enum logic [1:0] {
    ACTIVE  = 2'd0,
    STANDBY = 2'd1,
    SLEEP   = 2'd2,
    WAKE    = 2'd3
  } pwr_state_e;

  typedef struct packed {
    logic                we;
    logic [SPRAM_AW-1:0] addr;
    logic [SPRAM_DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/spram_arbiter_if.sv
// Requester-side bus of the SPRAM arbiter.
// Per-requester valid/ready request channel plus read response.
interface spram_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import spram_arb_pkg::*;

  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0]               req_we;
  logic [NUM_REQ-1:0][SPRAM_AW-1:0] req_addr;
  logic [NUM_REQ-1:0][SPRAM_DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]               rsp_valid;
  logic [SPRAM_DW-1:0]              rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/spram_arbiter_rr_arbiter.sv
// Round-robin grant: first requester at or after the pointer wins.
// Pointer moves past the winner only when the grant is consumed.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic          found;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[IW'((int'(ptr) + k) % N)]) begin
        found   = 1'b1;
        gnt_idx = IW'((int'(ptr) + k) % N);
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// Shares one byte-wide SPRAM bank between NUM_REQ requesters,
// with round-robin access and standby/sleep power management.
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int IDLE_CYCLES = 64,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  spram_arbiter_if.slave      bus,
  input  logic                sleep_req,
  output logic [1:0]          pwr_state,
  output logic [SPRAM_AW-1:0] mem_addr,
  output logic [SPRAM_DW-1:0] mem_din,
  output logic                mem_wren,
  output logic                mem_cs,
  output logic                mem_standby,
  output logic                mem_sleep,
  output logic                mem_poweroff_n,
  input  logic [SPRAM_DW-1:0] mem_dout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CMAX =
    (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int IDLE_M1 = (IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0;
  localparam int WAKE_M1 = (WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0;

  pwr_state_e    state, state_d;
  logic [CW-1:0] cnt, cnt_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               can_accept;
  logic               accept;
  logic               pipe_empty;
  logic               idle;

  req_t          sel, s1;
  logic          s1_cs;
  logic [IW-1:0] idx1, idx2;
  logic          rd2;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .advance (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // A pending sleep request blocks new work so the pipe drains.
  assign can_accept    = (state == ACTIVE) && !sleep_req;
  assign bus.req_ready = can_accept ? gnt : '0;
  assign accept        = can_accept && (|gnt);

  assign sel = '{
    we:    bus.req_we[gnt_idx],
    addr:  bus.req_addr[gnt_idx],
    wdata: bus.req_wdata[gnt_idx]
  };

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= '0;
      s1_cs <= 1'b0;
      idx1  <= '0;
      idx2  <= '0;
      rd2   <= 1'b0;
    end else begin
      s1_cs <= accept;
      if (accept) begin
        s1   <= sel;
        idx1 <= gnt_idx;
      end
      rd2  <= s1_cs && !s1.we;
      idx2 <= idx1;
    end
  end

  assign mem_cs         = s1_cs;
  assign mem_wren       = s1_cs && s1.we;
  assign mem_addr       = s1.addr;
  assign mem_din        = s1.wdata;
  assign mem_poweroff_n = 1'b1;

  always_comb begin
    bus.rsp_valid = '0;
    if (rd2) bus.rsp_valid[idx2] = 1'b1;
  end

  assign bus.rsp_rdata = mem_dout;

  assign pipe_empty = !s1_cs && !rd2;
  assign idle       = !(|bus.req_valid) && pipe_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACTIVE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // cnt is the idle counter in ACTIVE and the wake timer in WAKE.
  always_comb begin
    state_d = state;
    cnt_d   = '0;
    unique case (state)
      ACTIVE: begin
        if (sleep_req && pipe_empty) begin
          state_d = SLEEP;
        end else if (IDLE_CYCLES != 0 && idle) begin
          if (cnt == CW'(IDLE_M1)) state_d = STANDBY;
          else                     cnt_d   = cnt + 1'b1;
        end
      end
      STANDBY: begin
        if (sleep_req)               state_d = SLEEP;
        else if (|bus.req_valid)     state_d = WAKE;
      end
      SLEEP: begin
        if (!sleep_req) state_d = WAKE;
      end
      WAKE: begin
        if (sleep_req)                state_d = SLEEP;
        else if (cnt == CW'(WAKE_M1)) state_d = ACTIVE;
        else                          cnt_d   = cnt + 1'b1;
      end
    endcase
  end

  assign pwr_state   = state;
  assign mem_standby = (state == STANDBY);
  assign mem_sleep   = (state == SLEEP);

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter with a behavioural SPRAM model.
// Two requesters, IDLE_CYCLES=4, WAKE_CYCLES=2.
module tb_spram_arbiter;
  import spram_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        sleep_req;
  logic [1:0]  pwr_state;
  logic [16:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        mem_wren;
  logic        mem_cs;
  logic        mem_standby;
  logic        mem_sleep;
  logic        mem_poweroff_n;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sram [0:131071];

  spram_arbiter_if #(.NUM_REQ(2)) bus ();

  spram_arbiter #(
    .NUM_REQ     (2),
    .IDLE_CYCLES (4),
    .WAKE_CYCLES (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .sleep_req      (sleep_req),
    .pwr_state      (pwr_state),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_wren       (mem_wren),
    .mem_cs         (mem_cs),
    .mem_standby    (mem_standby),
    .mem_sleep      (mem_sleep),
    .mem_poweroff_n (mem_poweroff_n),
    .mem_dout       (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle read latency SPRAM model.
  always @(posedge clk) begin
    if (mem_cs === 1'b1) begin
      if (mem_wren === 1'b1) sram[mem_addr] <= mem_din;
      else                   mem_dout <= sram[mem_addr];
    end
  end

  always @(negedge clk) begin
    n_tests++;
    if (mem_poweroff_n !== 1'b1 ||
        (mem_cs === 1'b1 && (mem_standby !== 1'b0 || mem_sleep !== 1'b0))) begin
      n_fail++;
      $display("FAIL power_mon: poweroff_n=%b cs=%b standby=%b sleep=%b, want poweroff_n=1 and no cs while powered down",
               mem_poweroff_n, mem_cs, mem_standby, mem_sleep);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    sleep_req = 1'b0;
    idle_all();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    sleep_req = 1'b0;
    idle_all();
    tick();
    tick();
    @(negedge clk);
    n_tests++; if (mem_cs !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b want 0", mem_cs); end
    n_tests++; if (mem_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b want 0", mem_wren); end
    n_tests++; if (mem_addr !== 17'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    n_tests++; if (mem_din !== 8'h0) begin n_fail++; $display("FAIL reset_din: got %h want 0", mem_din); end
    n_tests++; if (mem_standby !== 1'b0) begin n_fail++; $display("FAIL reset_standby: got %b want 0", mem_standby); end
    n_tests++; if (mem_sleep !== 1'b0) begin n_fail++; $display("FAIL reset_sleep: got %b want 0", mem_sleep); end
    n_tests++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", bus.req_ready); end
    n_tests++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp: got %b want 00", bus.rsp_valid); end
    n_tests++; if (pwr_state !== ACTIVE) begin n_fail++; $display("FAIL reset_state: got %0d want 0", pwr_state); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    apply_reset();
    bus.req_valid = 2'b01; bus.req_we = 2'b01;
    bus.req_addr[0] = 17'h12345; bus.req_wdata[0] = 8'hA5;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL sr_wr_ready: got %b want 01", bus.req_ready); end
    tick();
    idle_all();
    bus.req_valid = 2'b10; bus.req_addr[1] = 17'h12345;
    @(negedge clk);
    n_tests++; if (mem_cs !== 1'b1) begin n_fail++; $display("FAIL sr_wr_cs: got %b want 1", mem_cs); end
    n_tests++; if (mem_wren !== 1'b1) begin n_fail++; $display("FAIL sr_wr_wren: got %b want 1", mem_wren); end
    n_tests++; if (mem_addr !== 17'h12345) begin n_fail++; $display("FAIL sr_wr_addr: got %h want 12345", mem_addr); end
    n_tests++; if (mem_din !== 8'hA5) begin n_fail++; $display("FAIL sr_wr_din: got %h want a5", mem_din); end
    n_tests++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL sr_rd_ready: got %b want 10", bus.req_ready); end
    tick();
    idle_all();
    @(negedge clk);
    n_tests++; if (mem_cs !== 1'b1 || mem_wren !== 1'b0) begin n_fail++; $display("FAIL sr_rd_cs: got cs=%b wren=%b want 1/0", mem_cs, mem_wren); end
    n_tests++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL sr_rsp_early: got %b want 00", bus.rsp_valid); end
    tick();
    @(negedge clk);
    n_tests++; if (bus.rsp_valid !== 2'b10) begin n_fail++; $display("FAIL sr_rsp_valid: got %b want 10", bus.rsp_valid); end
    n_tests++; if (bus.rsp_rdata !== 8'hA5) begin n_fail++; $display("FAIL sr_rsp_data: got %h want a5", bus.rsp_rdata); end
    n_tests++; if (mem_cs !== 1'b0) begin n_fail++; $display("FAIL sr_cs_idle: got %b want 0", mem_cs); end
    tick();
    @(negedge clk);
    n_tests++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL sr_rsp_once: got %b want 00", bus.rsp_valid); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy, exp_rsp;
    int cnt0, cnt1;
    apply_reset();
    bus.req_valid = 2'b11; bus.req_we = 2'b11;
    bus.req_addr[0] = 17'h00100; bus.req_wdata[0] = 8'h11;
    bus.req_addr[1] = 17'h00200; bus.req_wdata[1] = 8'h22;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL ct_wr0_ready: got %b want 01", bus.req_ready); end
    tick();
    bus.req_valid = 2'b10;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL ct_wr1_ready: got %b want 10", bus.req_ready); end
    tick();
    bus.req_we = 2'b00; bus.req_valid = 2'b11;
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) bus.req_valid = 2'b00;
      @(negedge clk);
      exp_rdy = (k >= 8) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
      exp_rsp = (k < 2) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
      n_tests++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL ct_ready[%0d]: got %b want %b", k, bus.req_ready, exp_rdy); end
      n_tests++; if (bus.rsp_valid !== exp_rsp) begin n_fail++; $display("FAIL ct_rsp[%0d]: got %b want %b", k, bus.rsp_valid, exp_rsp); end
      if (exp_rsp != 2'b00) begin
        n_tests++;
        if (bus.rsp_rdata !== ((k % 2 == 0) ? 8'h11 : 8'h22)) begin
          n_fail++; $display("FAIL ct_data[%0d]: got %h want %h", k, bus.rsp_rdata, (k % 2 == 0) ? 8'h11 : 8'h22);
        end
      end
      cnt0 += int'(bus.rsp_valid[0]);
      cnt1 += int'(bus.rsp_valid[1]);
      tick();
    end
    n_tests++; if (cnt0 != 4) begin n_fail++; $display("FAIL ct_count0: got %0d want 4", cnt0); end
    n_tests++; if (cnt1 != 4) begin n_fail++; $display("FAIL ct_count1: got %0d want 4", cnt1); end
  endtask

  task automatic test_auto_standby();
    apply_reset();
    bus.req_valid = 2'b01; bus.req_we = 2'b01;
    bus.req_addr[0] = 17'h0ABCD; bus.req_wdata[0] = 8'h5A;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL as_wr_ready: got %b want 01", bus.req_ready); end
    tick();
    idle_all();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_tests++;
      if (pwr_state !== ((k == 6) ? STANDBY : ACTIVE) ||
          mem_standby !== ((k == 6) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL as_idle[%0d]: got state=%0d standby=%b want %0d/%b",
                           k, pwr_state, mem_standby, (k == 6) ? 1 : 0, (k == 6) ? 1'b1 : 1'b0);
      end
      tick();
    end
    bus.req_valid = 2'b10; bus.req_addr[1] = 17'h0ABCD;
    @(negedge clk);
    n_tests++; if (pwr_state !== STANDBY || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL as_stby_hold: got state=%0d ready=%b want 1/00", pwr_state, bus.req_ready); end
    tick();
    @(negedge clk);
    n_tests++; if (pwr_state !== WAKE || mem_standby !== 1'b0 || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL as_wake1: got state=%0d standby=%b ready=%b want 3/0/00", pwr_state, mem_standby, bus.req_ready); end
    tick();
    @(negedge clk);
    n_tests++; if (pwr_state !== WAKE || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL as_wake2: got state=%0d ready=%b want 3/00", pwr_state, bus.req_ready); end
    tick();
    @(negedge clk);
    n_tests++; if (pwr_state !== ACTIVE || bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL as_accept: got state=%0d ready=%b want 0/10", pwr_state, bus.req_ready); end
    tick();
    idle_all();
    tick();
    @(negedge clk);
    n_tests++; if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== 8'h5A) begin n_fail++; $display("FAIL as_rsp: got valid=%b data=%h want 10/5a", bus.rsp_valid, bus.rsp_rdata); end
  endtask

  task automatic test_sleep();
    apply_reset();
    bus.req_valid = 2'b01; bus.req_we = 2'b01;
    bus.req_addr[0] = 17'h1F000; bus.req_wdata[0] = 8'h3C;
    tick();
    bus.req_we = 2'b00;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL sl_rd_ready: got %b want 01", bus.req_ready); end
    tick();
    idle_all();
    sleep_req = 1'b1;
    bus.req_valid = 2'b10; bus.req_addr[1] = 17'h1F000;
    @(negedge clk);
    n_tests++; if (mem_cs !== 1'b1 || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL sl_drain: got cs=%b ready=%b want 1/00", mem_cs, bus.req_ready); end
    tick();
    @(negedge clk);
    n_tests++; if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 8'h3C) begin n_fail++; $display("FAIL sl_rsp: got valid=%b data=%h want 01/3c", bus.rsp_valid, bus.rsp_rdata); end
    n_tests++; if (pwr_state !== ACTIVE || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL sl_pend: got state=%0d ready=%b want 0/00", pwr_state, bus.req_ready); end
    tick();
    @(negedge clk);
    n_tests++; if (pwr_state !== ACTIVE) begin n_fail++; $display("FAIL sl_empty: got state=%0d want 0", pwr_state); end
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) sleep_req = 1'b0;
      @(negedge clk);
      n_tests++;
      if (pwr_state !== SLEEP || mem_sleep !== 1'b1 || mem_standby !== 1'b0 || bus.req_ready !== 2'b00) begin
        n_fail++; $display("FAIL sl_sleep[%0d]: got state=%0d sleep=%b standby=%b ready=%b want 2/1/0/00",
                           k, pwr_state, mem_sleep, mem_standby, bus.req_ready);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_tests++;
      if (pwr_state !== WAKE || mem_sleep !== 1'b0 || bus.req_ready !== 2'b00) begin
        n_fail++; $display("FAIL sl_wake[%0d]: got state=%0d sleep=%b ready=%b want 3/0/00",
                           k, pwr_state, mem_sleep, bus.req_ready);
      end
      tick();
    end
    @(negedge clk);
    n_tests++; if (pwr_state !== ACTIVE || bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL sl_active: got state=%0d ready=%b want 0/10", pwr_state, bus.req_ready); end
    tick();
    idle_all();
    tick();
    @(negedge clk);
    n_tests++; if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== 8'h3C) begin n_fail++; $display("FAIL sl_rsp2: got valid=%b data=%h want 10/3c", bus.rsp_valid, bus.rsp_rdata); end
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    bus.req_valid = 2'b01; bus.req_addr[0] = 17'h1F000;
    tick();
    idle_all();
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (mem_cs !== 1'b1) begin n_fail++; $display("FAIL rm_inflight: got cs=%b want 1", mem_cs); end
    tick();
    rst = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_addr[0] = 17'h1F000; bus.req_addr[1] = 17'h1F000;
    @(negedge clk);
    n_tests++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rm_no_rsp: got %b want 00", bus.rsp_valid); end
    n_tests++; if (mem_cs !== 1'b0 || mem_wren !== 1'b0 || mem_addr !== 17'h0 || mem_din !== 8'h0) begin n_fail++; $display("FAIL rm_mem_rst: got cs=%b wren=%b addr=%h din=%h want 0/0/0/0", mem_cs, mem_wren, mem_addr, mem_din); end
    n_tests++; if (pwr_state !== ACTIVE || mem_standby !== 1'b0 || mem_sleep !== 1'b0) begin n_fail++; $display("FAIL rm_pwr_rst: got state=%0d standby=%b sleep=%b want 0/0/0", pwr_state, mem_standby, mem_sleep); end
    n_tests++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL rm_ptr_rst: got %b want 01", bus.req_ready); end
    tick();
    idle_all();
    @(negedge clk);
    n_tests++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rm_no_rsp2: got %b want 00", bus.rsp_valid); end
    tick();
    @(negedge clk);
    n_tests++; if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 8'h3C) begin n_fail++; $display("FAIL rm_new_rsp: got valid=%b data=%h want 01/3c", bus.rsp_valid, bus.rsp_rdata); end
  endtask

  task automatic test_addr_corners();
    logic [16:0] ca [5];
    logic [7:0]  cd [5];
    logic [1:0]  exp_rdy, exp_rsp;
    int r;
    ca = '{17'h00000, 17'h07FFF, 17'h08000, 17'h1FFFF, 17'h00001};
    cd = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      idle_all();
      if (i < 10) begin
        r = i % 2;
        bus.req_valid[r] = 1'b1;
        bus.req_we[r]    = (i < 5);
        bus.req_addr[r]  = ca[i % 5];
        bus.req_wdata[r] = cd[i % 5];
      end
      @(negedge clk);
      exp_rdy = (i < 10) ? ((i % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_rsp = (i >= 7) ? ((i % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      n_tests++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL ac_ready[%0d]: got %b want %b", i, bus.req_ready, exp_rdy); end
      n_tests++; if (bus.rsp_valid !== exp_rsp) begin n_fail++; $display("FAIL ac_rsp[%0d]: got %b want %b", i, bus.rsp_valid, exp_rsp); end
      if (i >= 7) begin
        n_tests++;
        if (bus.rsp_rdata !== cd[i - 7]) begin
          n_fail++; $display("FAIL ac_data[%h]: got %h want %h", ca[i - 7], bus.rsp_rdata, cd[i - 7]);
        end
      end
      tick();
    end
  endtask

  initial begin
    rst       = 1'b1;
    sleep_req = 1'b0;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_auto_standby();
    test_sleep();
    test_reset_mid_read();
    test_addr_corners();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Shares one 128 KiB byte-wide single-port SPRAM bank (4x SPRAM256K wrapper: 17-bit byte address, 8-bit data, 1-cycle read latency) between NUM_REQ requesters, e.g. CPU and DMA/PPU.
- Round-robin arbitration; pipelined valid/ready request channels; read responses routed back to the issuing requester.
- Manages SPRAM power: automatic standby after idle, software-requested sleep, timed wake-up.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- IDLE_CYCLES, 64, consecutive idle cycles before automatic standby; 0 disables auto-standby
- WAKE_CYCLES, 2, cycles that standby/sleep stays deasserted before accesses resume (min 1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  request valid per requester
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ x 17  byte address per requester
- req_wdata  in  NUM_REQ x 8  write data per requester
- rsp_valid  out  NUM_REQ  read data valid for that requester
- rsp_rdata  out  8  read data, shared by all requesters
- sleep_req  in  1  level request to put the SPRAM into sleep
- pwr_state  out  2  0 ACTIVE, 1 STANDBY, 2 SLEEP, 3 WAKE
- mem_addr  out  17  to SPRAM wrapper addr
- mem_din  out  8  to SPRAM wrapper din
- mem_wren  out  1  to SPRAM wrapper wren
- mem_cs  out  1  to SPRAM wrapper cs
- mem_standby  out  1  to SPRAM wrapper standby
- mem_sleep  out  1  to SPRAM wrapper sleep
- mem_poweroff_n  out  1  to SPRAM wrapper poweroff_n; tied to 1, contents always retained
- mem_dout  in  8  from SPRAM wrapper dout

Behaviour:
- Reset values:
  - mem_cs = 0, mem_wren = 0, mem_addr = 0, mem_din = 0.
  - mem_standby = 0, mem_sleep = 0, mem_poweroff_n = 1.
  - req_ready = 0, rsp_valid = 0.
  - State ACTIVE, round-robin pointer favours requester 0, idle counter 0.
- Reset mid-operation: in-flight reads are discarded; no rsp_valid is produced after reset.
- Arbitration (ACTIVE only):
  - The grant goes to the first valid requester at or after the pointer, in circular order.
  - req_ready is combinational from req_valid, state and pointer. A request is accepted when req_valid & req_ready.
  - After each grant, the pointer moves to granted+1 (mod NUM_REQ).
  - At most one acceptance per cycle. Throughput is 1 access per cycle.
- Pipeline, for a request accepted in cycle N:
  - Cycle N+1: mem_cs = 1, with mem_addr, mem_wren and mem_din registered from the request.
  - Read: rsp_valid[i] = 1 in cycle N+2, rsp_rdata = mem_dout (combinational pass-through). A 2-stage tag pipeline carries requester index and read flag.
  - Write: no response. Writes are complete at the N+1 edge.
  - Cycles with no acceptance: mem_cs = 0 and mem_wren = 0 in the next cycle.
- Read-after-write to the same address from any requester returns the new data; the single-port ordering guarantees this.
- Power FSM:
  - ACTIVE -> SLEEP when sleep_req = 1 and the pipeline is empty. While sleep_req = 1, req_ready is held 0 so the pipeline drains.
  - ACTIVE -> STANDBY when IDLE_CYCLES != 0 and the idle counter reaches IDLE_CYCLES. The idle counter counts cycles with no req_valid and an empty pipeline; it clears on any req_valid or on any state change.
  - STANDBY: mem_standby = 1, req_ready = 0.
    - Any req_valid -> WAKE.
    - sleep_req -> SLEEP.
    - sleep_req has priority when both occur.
  - SLEEP: mem_sleep = 1, mem_standby = 0, req_ready = 0.
    - sleep_req = 0 -> WAKE.
    - req_valid alone does not wake.
  - WAKE: mem_standby = 0, mem_sleep = 0, req_ready = 0, for WAKE_CYCLES cycles, then -> ACTIVE.
    - sleep_req asserted during WAKE -> SLEEP.
  - mem_cs is never 1 outside ACTIVE or the drain cycle that follows it.
- Requests wait (valid held, no timeout). Requesters keep their request stable until ready, per the standard valid/ready rule.

Decomposition:
- Package spram_arb_pkg:
  - pwr_state_e enum: ACTIVE = 0, STANDBY = 1, SLEEP = 2, WAKE = 3.
  - SPRAM_AW = 17, SPRAM_DW = 8.
  - Request struct: we, addr, wdata.
- One sub-module: rr_arbiter, a parameterized round-robin grant with a pointer register and an advance-on-grant input.

Test Plan:
- Single read: write 0xA5 to 0x1_2345 from requester 0, then read it from requester 1 -> mem_cs=1 one cycle after each acceptance; rsp_valid[1]=1 two cycles after read acceptance with rsp_rdata=0xA5; rsp_valid[0] stays 0.
- Contention: both requesters hold reads continuously -> grants alternate 0,1,0,1; each requester receives back-to-back responses every other cycle in issue order; no lost or duplicated rsp_valid.
- Auto-standby: IDLE_CYCLES=4, no requests -> pwr_state=STANDBY and mem_standby=1 after 4 idle cycles. A read arriving then is accepted exactly WAKE_CYCLES+1 cycles later, and the data is intact.
- Sleep: assert sleep_req with a read in flight -> the response is still delivered, then mem_sleep=1. req_valid while sleeping gets no ready. Deassert -> WAKE for 2 cycles, then ACTIVE.
- Reset mid-read: accept a read, assert rst the next cycle -> no rsp_valid afterwards; all outputs at reset values; mem_poweroff_n=1 throughout.
- Address corners: write/read 0x0_0000, 0x0_7FFF, 0x0_8000, 0x1_FFFF with distinct bytes -> each read returns its own byte; even and odd addresses do not corrupt each other.
